// File: rtl/reg_bank_mp.sv
// Multi-read-port register bank with registered, write-first reads, an optional
// hard-wired zero entry and a sequential clear engine run after reset or on flush.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | normal operation; reads and writes accepted
// S_CLEAR | zeroing entry[r_cnt] each cycle; reads and writes ignored
module reg_bank_mp #(
   parameter int DW       = 64,
   parameter int DEPTH    = 256,
   parameter int AW       = 8,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic              rd_en,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*DW-1:0] rd_data,
   output logic              rd_valid,
   input  logic              flush_req,
   output logic              busy,
   output logic              flush_done
);

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_cnt;
   logic [DW-1:0]     r_mem [DEPTH];
   logic [NRD*DW-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_flush_done;

   logic              w_busy;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_clr_last;
   logic [AW-1:0]     w_ra     [NRD];
   logic [DW-1:0]     w_rd_nxt [NRD];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_CLEAR;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (flush_req)  w_state_nxt = S_CLEAR;
         S_CLEAR: if (w_clr_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   always_comb begin
      w_busy     = (r_state == S_CLEAR);
      w_wr_acc   = !w_busy && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
      w_rd_acc   = !w_busy && rd_en;
      w_clr_last = w_busy && (r_cnt == AW'(DEPTH - 1));
   end

   // DEPTH is a power of two, so the counter wraps to 0 on its own after DEPTH-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_flush_done <= 1'b0;
      end else begin
         r_cnt        <= w_busy ? r_cnt + 1'b1 : '0;
         r_flush_done <= w_clr_last;
      end
   end

   always_ff @(posedge clk) begin
      if (w_busy)        r_mem[r_cnt]   <= '0;
      else if (w_wr_acc) r_mem[wr_addr] <= wr_data;
   end

   // Zero entry wins over bypass; bypass wins over the stored value.
   for (genvar g = 0; g < NRD; g++) begin : g_rd
      assign w_ra[g]     = rd_addr[g*AW +: AW];
      assign w_rd_nxt[g] = ((ZERO_REG != 0) && (w_ra[g] == '0)) ? '0 :
                           (w_wr_acc && (w_ra[g] == wr_addr))  ? wr_data :
                                                                 r_mem[w_ra[g]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            for (int k = 0; k < NRD; k++) r_rd_data[k*DW +: DW] <= w_rd_nxt[k];
         end
      end
   end

   assign rd_data    = r_rd_data;
   assign rd_valid   = r_rd_valid;
   assign busy       = w_busy;
   assign flush_done = r_flush_done;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: two instances (ZERO_REG 0 and 1) share one stimulus
// stream; a behavioural model predicts status and read data into per-instance queues.
module tb_reg_bank_mp;
   localparam int DW = 64, DEPTH = 256, AW = 8, NRD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, wr_en, rd_en, flush_req;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data0, rd_data1;
   logic              rd_valid0, rd_valid1, busy0, busy1, done0, done1;

   reg_bank_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .ZERO_REG(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .flush_req(flush_req), .busy(busy0), .flush_done(done0));

   reg_bank_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .ZERO_REG(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .flush_req(flush_req), .busy(busy1), .flush_done(done1));

   logic [DW-1:0]  m_mem0 [DEPTH];
   logic [DW-1:0]  m_mem1 [DEPTH];
   logic [127:0]   q0 [$];
   logic [127:0]   q1 [$];
   logic [127:0]   m_last0 = '0, m_last1 = '0;
   bit             m_busy = 1'b1, m_done = 1'b0, m_rv = 1'b0;
   int             m_cnt = 0;
   int             n_cmp = 0, n_err = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check_eq("busy0", busy0, m_busy);
      check_eq("busy1", busy1, m_busy);
      check_eq("flush_done0", done0, m_done);
      check_eq("flush_done1", done1, m_done);
      check_eq("rd_valid0", rd_valid0, m_rv);
      check_eq("rd_valid1", rd_valid1, m_rv);
      if (rd_valid0) begin
         check_eq("q0_pending", q0.size() != 0, 1'b1);
         if (q0.size() != 0) m_last0 = q0.pop_front();
      end
      if (rd_valid1) begin
         check_eq("q1_pending", q1.size() != 0, 1'b1);
         if (q1.size() != 0) m_last1 = q1.pop_front();
      end
      check_eq("rd_data0", rd_data0, m_last0);
      check_eq("rd_data1", rd_data1, m_last1);
   end

   task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input bit fr);
      bit            nb, nd, nrv;
      int            nc;
      logic [DW-1:0] d0 [2];
      logic [DW-1:0] d1 [2];
      logic [AW-1:0] ra [2];
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = {ra1, ra0}; flush_req = fr;
      ra[0] = ra0; ra[1] = ra1;
      nrv = !m_busy && re;
      if (nrv) begin
         for (int k = 0; k < 2; k++) begin
            d0[k] = (we && wa == ra[k]) ? wd : m_mem0[ra[k]];
            d1[k] = (ra[k] == 0) ? '0 : (we && wa == ra[k]) ? wd : m_mem1[ra[k]];
         end
         q0.push_back({d0[1], d0[0]});
         q1.push_back({d1[1], d1[0]});
      end
      if (m_busy) begin
         m_mem0[m_cnt] = '0;
         m_mem1[m_cnt] = '0;
         nd = (m_cnt == DEPTH - 1);
         nb = !nd;
         nc = nd ? 0 : m_cnt + 1;
      end else begin
         if (we) begin
            m_mem0[wa] = wd;
            if (wa != 0) m_mem1[wa] = wd;
         end
         nb = fr; nd = 1'b0; nc = 0;
      end
      @(posedge clk);
      m_busy = nb; m_done = nd; m_rv = nrv; m_cnt = nc;
      #1;
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      step(1'b0, '0, '0, 1'b1, a0, a1, 1'b0);
   endtask

   task automatic hold_reset(input int n);
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0; flush_req = 1'b0;
      m_busy = 1'b1; m_done = 1'b0; m_rv = 1'b0; m_cnt = 0;
      m_last0 = '0; m_last1 = '0;
      q0.delete(); q1.delete();
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         m_mem0[i] = '0;
         m_mem1[i] = '0;
      end
      hold_reset(3);
      repeat (DEPTH + 3) idle();

      for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(DEPTH - 1 - i));
      idle();

      step(1'b1, 8'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, '0, '0, 1'b0);
      rd(8'd5, 8'd6);
      idle();

      step(1'b1, 8'd9, 64'h1234, 1'b1, 8'd9, 8'd9, 1'b0);
      idle();

      step(1'b1, 8'd0, 64'hFFFF, 1'b1, 8'd0, 8'd0, 1'b0);
      step(1'b1, 8'd1, 64'hFFFF, 1'b1, 8'd0, 8'd1, 1'b0);
      rd(8'd0, 8'd1);
      idle();

      step(1'b1, 8'd3, 64'h77, 1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 8'd3, 8'd3, 1'b1);
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 8'd4, 64'h88, 1'b1, 8'd3, 8'd4, i == 50);
      // flush_done is visible now: a new request in this cycle must be taken
      step(1'b1, 8'd7, 64'hAB, 1'b1, 8'd3, 8'd4, 1'b1);
      repeat (DEPTH) idle();
      rd(8'd3, 8'd4);
      rd(8'd7, 8'd9);
      idle();

      for (int i = 0; i < 150; i++)
         step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'b0);
      idle();

      rd(8'd1, 8'd2);
      hold_reset(2);
      repeat (100) idle();
      hold_reset(3);
      repeat (DEPTH + 2) idle();
      rd(8'd1, 8'd5);
      rd(8'd0, 8'd255);
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
